bsg_counter_set_up_timer: RTL and testbench

//  Programmable interval timer: loads a limit, then counts up from 0 on up_i

---
 rtl/bsg_counter_set_up_timer_pkg.sv | 17 +
 rtl/bsg_counter_set_up_timer_if.sv | 33 +++
 rtl/bsg_counter_clear_up_cmp.sv | 41 ++++
 rtl/bsg_counter_set_up_timer.sv | 126 ++++++++++++
 tb/tb_bsg_counter_set_up_timer.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bsg_counter_set_up_timer_pkg.sv
// Shared types for the set-up timer.
// Contents:
//   state_e : controller state
//     IDLE  - no limit loaded yet
//     ARMED - limit held, count at 0
//     RUN   - counting up
//     DONE  - count equals limit, held
package bsg_counter_set_up_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/bsg_counter_set_up_timer_if.sv
// Control/status bundle of the set-up timer.
// Signals:
//   limit_v_i / limit_i / limit_ready_o : limit load handshake
//   start_i, auto_reload_i              : begin a run, periodic mode select
//   up_i, abort_i                       : increment enable, stop
//   count_r_o, busy_o, done_o           : registered status
// Modports:
//   master : the user of the timer (drives the *_i signals)
//   slave  : the timer itself
interface bsg_counter_set_up_timer_if #(parameter int width_p = 32);

    logic               limit_v_i;
    logic [width_p-1:0] limit_i;
    logic               limit_ready_o;
    logic               start_i;
    logic               auto_reload_i;
    logic               up_i;
    logic               abort_i;
    logic [width_p-1:0] count_r_o;
    logic               busy_o;
    logic               done_o;

    modport master (
        output limit_v_i, limit_i, start_i, auto_reload_i, up_i, abort_i,
        input  limit_ready_o, count_r_o, busy_o, done_o
    );

    modport slave (
        input  limit_v_i, limit_i, start_i, auto_reload_i, up_i, abort_i,
        output limit_ready_o, count_r_o, busy_o, done_o
    );

endinterface

// File: rtl/bsg_counter_clear_up_cmp.sv
// Count register with synchronous clear and increment, plus a terminal-match
// flag telling whether the next increment would land exactly on the limit.
// Ports:
//   clk   in  1        rising-edge clock
//   rst_n in  1        asynchronous active-low reset
//   clear in  1        force count to 0 (wins over incr)
//   incr  in  1        count + 1
//   limit in  width_p  terminal value to compare against
//   count out width_p  registered count
//   hit   out 1        count + 1 == limit
module bsg_counter_clear_up_cmp #(
    parameter int width_p = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               incr,
    input  logic [width_p-1:0] limit,
    output logic [width_p-1:0] count,
    output logic               hit
);

    // One extra bit so count+1 cannot wrap when limit is all-ones.
    logic [width_p:0] count_plus;

    assign count_plus = {1'b0, count} + {{width_p{1'b0}}, 1'b1};
    assign hit        = (count_plus == {1'b0, limit});

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of block evaluation order.
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (incr) begin
            count <= count_plus[width_p-1:0];
        end
    end

endmodule

// File: rtl/bsg_counter_set_up_timer.sv
// Programmable interval timer: load a limit, count up from 0 on up_i until the
// limit is reached, then raise a one-cycle done pulse. Optional auto-reload
// wraps to 0 at the limit and keeps running, giving a periodic tick.
// Ports:
//   clk_i     in  1  rising-edge clock
//   reset_n_i in  1  asynchronous active-low reset
//   bus       slave side of bsg_counter_set_up_timer_if (handshake + status)
// Per-cycle priority: abort > limit load > start > up.
module bsg_counter_set_up_timer
    import bsg_counter_set_up_timer_pkg::*;
#(
    parameter int width_p = 32
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    bsg_counter_set_up_timer_if.slave     bus
);

    state_e             state_r, state_n;
    logic [width_p-1:0] limit_r;
    logic               reload_r;
    logic               done_r, done_n;
    logic               limit_we, reload_we;
    logic               clear, incr, hit;
    logic [width_p-1:0] count;

    bsg_counter_clear_up_cmp #(.width_p(width_p)) counter (
        .clk   (clk_i),
        .rst_n (reset_n_i),
        .clear (clear),
        .incr  (incr),
        .limit (limit_r),
        .count (count),
        .hit   (hit)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no branch
        // can leave one unassigned and infer a latch.
        state_n   = state_r;
        clear     = 1'b0;
        incr      = 1'b0;
        done_n    = 1'b0;
        limit_we  = 1'b0;
        reload_we = 1'b0;

        unique case (state_r)
            IDLE: begin
                if (bus.limit_v_i) begin
                    limit_we = 1'b1;
                    clear    = 1'b1;
                    state_n  = ARMED;
                end
            end

            // A re-run from DONE behaves exactly like a first run from ARMED.
            ARMED, DONE: begin
                if (bus.abort_i) begin
                    clear   = 1'b1;
                    state_n = ARMED;
                end else if (bus.limit_v_i) begin
                    limit_we = 1'b1;
                    clear    = 1'b1;
                    state_n  = ARMED;
                end else if (bus.start_i) begin
                    reload_we = 1'b1;
                    clear     = 1'b1;
                    // Zero limit finishes immediately; it never enters RUN,
                    // so auto-reload cannot turn it into a pulse train.
                    if (limit_r == '0) begin
                        done_n  = 1'b1;
                        state_n = DONE;
                    end else begin
                        state_n = RUN;
                    end
                end
            end

            RUN: begin
                if (bus.abort_i) begin
                    clear   = 1'b1;
                    state_n = ARMED;
                end else if (bus.up_i) begin
                    if (hit) begin
                        done_n = 1'b1;
                        if (reload_r) begin
                            clear = 1'b1;
                        end else begin
                            // count+1 == limit, so incrementing lands on limit.
                            incr    = 1'b1;
                            state_n = DONE;
                        end
                    end else begin
                        incr = 1'b1;
                    end
                end
            end

            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r  <= IDLE;
            limit_r  <= '0;
            reload_r <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r <= state_n;
            done_r  <= done_n;
            if (limit_we) begin
                limit_r <= bus.limit_i;
            end
            if (reload_we) begin
                reload_r <= bus.auto_reload_i;
            end
        end
    end

    assign bus.limit_ready_o = (state_r != RUN);
    assign bus.busy_o        = (state_r == RUN);
    assign bus.done_o        = done_r;
    assign bus.count_r_o     = count;

endmodule

// File: tb/tb_bsg_counter_set_up_timer.sv
// Self-checking bench for bsg_counter_set_up_timer: directed scenarios with
// literal expectations, a randomized phase, and a behavioural model compared
// against the 32-bit instance on every falling edge. An 8-bit instance covers
// the all-ones limit boundary in a practical number of cycles.
module tb_bsg_counter_set_up_timer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   cmp_en = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    bsg_counter_set_up_timer_if #(.width_p(32)) bus ();
    bsg_counter_set_up_timer_if #(.width_p(8))  bus8 ();

    bsg_counter_set_up_timer #(.width_p(32)) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .bus       (bus)
    );

    bsg_counter_set_up_timer #(.width_p(8)) dut8 (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .bus       (bus8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {M_IDLE, M_ARMED, M_RUN, M_DONE} mstate_e;
    typedef struct {
        mstate_e     st;
        logic [31:0] limit;
        logic [31:0] count;
        bit          reload;
        bit          done;
    } model_t;

    model_t m;

    function automatic model_t model_next(input model_t cur, input bit lv, input logic [31:0] l,
                                          input bit st, input bit ar, input bit up, input bit ab);
        model_t n = cur;
        n.done = 1'b0;
        case (cur.st)
            M_IDLE: if (lv) begin n.limit = l; n.count = 0; n.st = M_ARMED; end
            M_ARMED, M_DONE: begin
                if (ab) begin
                    n.count = 0; n.st = M_ARMED;
                end else if (lv) begin
                    n.limit = l; n.count = 0; n.st = M_ARMED;
                end else if (st) begin
                    n.reload = ar;
                    n.count  = 0;
                    if (cur.limit == 0) begin n.st = M_DONE; n.done = 1'b1; end
                    else n.st = M_RUN;
                end
            end
            M_RUN: begin
                if (ab) begin
                    n.count = 0; n.st = M_ARMED;
                end else if (up) begin
                    if (longint'(cur.count) + 1 == longint'(cur.limit)) begin
                        n.done = 1'b1;
                        if (cur.reload) n.count = 0;
                        else begin n.count = cur.limit; n.st = M_DONE; end
                    end else begin
                        n.count = cur.count + 1;
                    end
                end
            end
            default: n.st = M_IDLE;
        endcase
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '{M_IDLE, 32'd0, 32'd0, 1'b0, 1'b0};
        else m <= model_next(m, bus.limit_v_i, bus.limit_i, bus.start_i,
                             bus.auto_reload_i, bus.up_i, bus.abort_i);
    end

    // Single compare process: DUT vs model on every falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_count", bus.count_r_o, m.count);
            check("model_done",  bus.done_o, m.done);
            check("model_busy",  bus.busy_o, m.st == M_RUN);
            check("model_ready", bus.limit_ready_o, m.st != M_RUN);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit lv, input logic [31:0] l, input bit st,
                         input bit ar, input bit up, input bit ab);
        bus.limit_v_i     = lv;
        bus.limit_i       = l;
        bus.start_i       = st;
        bus.auto_reload_i = ar;
        bus.up_i          = up;
        bus.abort_i       = ab;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic outs(input string tag, input logic [31:0] c, input bit b,
                        input bit d, input bit r);
        check({tag, "_count"}, bus.count_r_o, c);
        check({tag, "_busy"},  bus.busy_o, b);
        check({tag, "_done"},  bus.done_o, d);
        check({tag, "_ready"}, bus.limit_ready_o, r);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        bus8.limit_v_i = 0; bus8.limit_i = '0; bus8.start_i = 0;
        bus8.auto_reload_i = 0; bus8.up_i = 0; bus8.abort_i = 0;

        // Reset values.
        step();
        outs("reset", 0, 0, 0, 1);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // Limit 3, single shot, continuous up.
        drive(1, 3, 0, 0, 0, 0); step(); outs("ld3", 0, 0, 0, 1);
        drive(0, 0, 1, 0, 1, 0); step(); outs("run3_c0", 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 0); step(); outs("run3_c1", 1, 1, 0, 0);
        step(); outs("run3_c2", 2, 1, 0, 0);
        step(); outs("run3_term", 3, 0, 1, 1);
        step(); outs("run3_hold", 3, 0, 0, 1);

        // Asynchronous reset in the middle of a clock phase.
        @(posedge clk); #2 rst_n = 1'b0;
        #1 outs("async_rst", 0, 0, 0, 1);
        @(negedge clk); rst_n = 1'b1;

        // Auto-reload with limit 2, then abort.
        drive(1, 2, 0, 0, 1, 0); step(); outs("ld2", 0, 0, 0, 1);
        drive(0, 0, 1, 1, 1, 0); step(); outs("ar_c0", 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 0); step(); outs("ar_c1", 1, 1, 0, 0);
        step(); outs("ar_wrap1", 0, 1, 1, 0);
        step(); outs("ar_c1b", 1, 1, 0, 0);
        step(); outs("ar_wrap2", 0, 1, 1, 0);
        drive(0, 0, 0, 0, 1, 1); step(); outs("ar_abort", 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1, 0); repeat (3) step(); outs("ar_quiet", 0, 0, 0, 1);

        // Limit 0 with auto-reload: single pulse, straight to DONE.
        drive(1, 0, 0, 0, 0, 0); step(); outs("ld0", 0, 0, 0, 1);
        drive(0, 0, 1, 1, 0, 0); step(); outs("z_done", 0, 0, 1, 1);
        drive(0, 0, 0, 0, 1, 0); step(); outs("z_hold", 0, 0, 0, 1);

        // All-ones limit on the wide instance: start counting, then abort.
        drive(1, 32'hFFFF_FFFF, 0, 0, 0, 0); step();
        drive(0, 0, 1, 0, 0, 0); step();
        drive(0, 0, 0, 0, 1, 0); step(); step(); outs("max_c2", 2, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 1); step(); outs("max_abort", 0, 0, 0, 1);

        // Abort colliding with a terminal increment.
        drive(1, 2, 0, 0, 0, 0); step();
        drive(0, 0, 1, 0, 1, 0); step(); outs("col_c0", 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 0); step(); outs("col_c1", 1, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 1); step(); outs("col_abort", 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0); step(); outs("col_nopulse", 0, 0, 0, 1);

        // Limit offered during RUN is refused; original limit 5 still applies.
        drive(1, 5, 0, 0, 0, 0); step();
        drive(0, 0, 1, 0, 1, 0); step();
        drive(1, 1, 0, 0, 1, 0); step(); outs("run_ld_refused", 1, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 0); repeat (3) step(); outs("run5_c4", 4, 1, 0, 0);
        step(); outs("run5_term", 5, 0, 1, 1);

        // Load and start together in DONE: load wins, new limit 3 used.
        drive(1, 3, 1, 0, 0, 0); step(); outs("ld_wins", 0, 0, 0, 1);
        drive(0, 0, 1, 0, 1, 0); step();
        drive(0, 0, 0, 0, 1, 0); repeat (3) step(); outs("new3_term", 3, 0, 1, 1);

        // up_i gaps: limit 4, up toggled each cycle.
        drive(1, 4, 0, 0, 0, 0); step();
        drive(0, 0, 1, 0, 0, 0); step();
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 0, (i % 2) == 0, 0);
            step();
            check("gap_count", bus.count_r_o, (i >= 6) ? 4 : (i / 2 + 1));
            check("gap_done",  bus.done_o, i == 6);
            check("gap_busy",  bus.busy_o, i < 6);
        end

        // Randomized phase, checked by the compare process.
        for (int i = 0; i < 4000; i++) begin
            int unsigned sel;
            logic [31:0] lim;
            sel = $urandom_range(0, 9);
            lim = (sel == 0) ? 32'd0 : (sel == 9) ? 32'hFFFF_FFFF : 32'($urandom_range(1, 6));
            drive($urandom_range(0, 7) == 0, lim, $urandom_range(0, 5) == 0,
                  1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 31) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                #1 check("rnd_async_rst_count", bus.count_r_o, 0);
                check("rnd_async_rst_done", bus.done_o, 0);
                @(negedge clk); rst_n = 1'b1;
            end else begin
                step();
            end
        end
        drive(0, 0, 0, 0, 0, 0);
        step();

        // All-ones limit on the narrow instance: 254 -> 255 terminal.
        bus8.limit_v_i = 1; bus8.limit_i = 8'hFF; step();
        bus8.limit_v_i = 0; bus8.start_i = 1; step();
        check("w8_run", bus8.busy_o, 1);
        bus8.start_i = 0; bus8.up_i = 1;
        repeat (254) step();
        check("w8_c254", bus8.count_r_o, 8'hFE);
        check("w8_c254_done", bus8.done_o, 0);
        step();
        check("w8_term_count", bus8.count_r_o, 8'hFF);
        check("w8_term_done", bus8.done_o, 1);
        check("w8_term_busy", bus8.busy_o, 0);
        bus8.up_i = 0; step();
        check("w8_hold_count", bus8.count_r_o, 8'hFF);
        check("w8_hold_done", bus8.done_o, 0);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
